// File: rtl/rs485_pkg.sv
// rs485_pkg: items shared by the RS485 receive and transmit sides.
//   - frame parser state encoding
//   - default frame header and LED command codes
//   - frame checksum helper: 8-bit sum, carry dropped
package rs485_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_CHK  = 2'd3;

  localparam logic [7:0] HEADER_DEF  = 8'hAA;
  localparam logic [7:0] CMD_LED_DEF = 8'h01;

  function automatic logic [7:0] frame_sum(input logic [7:0] cmd, input logic [7:0] data);
    return cmd + data;
  endfunction

endpackage

// File: rtl/rs485_byte_timeout.sv
// rs485_byte_timeout: inter-byte watchdog for the frame parser.
//   clk      in   system clock
//   rst_n    in   asynchronous reset, active low
//   run      in   count while high; the counter is held at zero while low
//   kick     in   byte received; restarts the count
//   expired  out  1-cycle pulse on the cycle the count reaches TIMEOUT_CYC-1
//                 with no kick in that cycle
module rs485_byte_timeout #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic kick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  // A kick in the expiry cycle suppresses the pulse: the byte wins.
  assign expired = run && !kick && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || kick || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/rs485_cmd_parser.sv
// rs485_cmd_parser: collects UART bytes into HEADER/CMD/DATA/CHECKSUM frames
// and drives the LED stage.
//   clk        in   system clock
//   rst_n      in   asynchronous reset, active low
//   uart_done  in   1-cycle strobe, uart_data holds a received byte
//   uart_data  in   received byte
//   led_en     out  1-cycle strobe, led_data is valid
//   led_data   out  DATA[3:0] of the last good LED frame
//   frame_err  out  1-cycle strobe, frame rejected (checksum, command, timeout)
//
// state | meaning
// IDLE  | hunting for HEADER, other bytes dropped silently
// CMD   | header seen, next byte is the command
// DATA  | next byte is the data
// CHK   | next byte is the checksum, frame is resolved on it
module rs485_cmd_parser
  import rs485_pkg::*;
#(
  parameter logic [7:0] HEADER      = HEADER_DEF,
  parameter logic [7:0] CMD_LED     = CMD_LED_DEF,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_done,
  input  logic [7:0] uart_data,
  output logic       led_en,
  output logic [3:0] led_data,
  output logic       frame_err
);

  logic [1:0] state;
  logic [7:0] cmd;
  logic [7:0] data;
  logic       expired;

  rs485_byte_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (state != ST_IDLE),
    .kick   (uart_done),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cmd       <= '0;
      data      <= '0;
      led_en    <= 1'b0;
      led_data  <= '0;
      frame_err <= 1'b0;
    end else begin
      led_en    <= 1'b0;
      frame_err <= 1'b0;
      if (uart_done) begin
        // A header byte past IDLE is ordinary payload; no resync.
        case (state)
          ST_IDLE: if (uart_data == HEADER) state <= ST_CMD;
          ST_CMD: begin
            cmd   <= uart_data;
            state <= ST_DATA;
          end
          ST_DATA: begin
            data  <= uart_data;
            state <= ST_CHK;
          end
          ST_CHK: begin
            state <= ST_IDLE;
            if ((uart_data == frame_sum(cmd, data)) && (cmd == CMD_LED)) begin
              led_en   <= 1'b1;
              led_data <= data[3:0];
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (expired) begin
        state     <= ST_IDLE;
        frame_err <= 1'b1;
      end
    end
  end

endmodule
